// File: rtl/phase_timer_pkg.sv
// Shared constants and types for the phase timer.
// Holds reset durations, phase indices, FSM states.
package phase_timer_pkg;

  localparam int RED_T = 35;
  localparam int YEL_T = 4;
  localparam int GRN_T = 25;
  localparam int DEF_T = 10;

  localparam int PH_RED = 0;
  localparam int PH_YEL = 1;
  localparam int PH_GRN = 2;

  typedef enum logic {
    PAUSE = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Untruncated reset duration of phase i.
  function automatic int rst_dur(input int i);
    if (i == PH_RED) return RED_T;
    if (i == PH_YEL) return YEL_T;
    if (i == PH_GRN) return GRN_T;
    return DEF_T;
  endfunction

endpackage

// File: rtl/dur_bank.sv
// Duration register bank: validated writes, readback.
// Ports: wr_* write, rd_* readback, wr_err pulse, dur_o bank.
import phase_timer_pkg::*;

module dur_bank #(
  parameter int NUM_PHASES = 3,
  parameter int TW         = 7,
  parameter int SW         = $clog2(NUM_PHASES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [SW-1:0]                  wr_sel,
  input  logic [TW-1:0]                  wr_data,
  input  logic [SW-1:0]                  rd_sel,
  output logic [TW-1:0]                  rd_data,
  output logic                           wr_err,
  output logic [NUM_PHASES-1:0][TW-1:0]  dur_o
);

  logic [NUM_PHASES-1:0][TW-1:0] dur_q, dur_d;
  logic                          wr_err_q, wr_err_d;
  logic                          wr_ok;

  always_comb begin
    wr_ok    = wr_en
             && (int'(wr_sel) < NUM_PHASES)
             && (wr_data != '0);
    wr_err_d = wr_en && !wr_ok;
    dur_d    = dur_q;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (wr_ok && int'(wr_sel) == i)
        dur_d[i] = wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (int'(rd_sel) == i)
        rd_data = dur_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++)
        dur_q[i] <= TW'(rst_dur(i));
      wr_err_q <= 1'b0;
    end else begin
      dur_q    <= dur_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;
  assign dur_o  = dur_q;

endmodule

// File: rtl/phase_timer.sv
// Multi-phase countdown timer with programmable durations.
// Ports: tick/run/restart control, wr_*/rd_* bank, phase/remain status.
import phase_timer_pkg::*;

module phase_timer #(
  parameter int NUM_PHASES = 3,
  parameter int TW         = 7,
  parameter int SW         = $clog2(NUM_PHASES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          run,
  input  logic          restart,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_sel,
  input  logic [TW-1:0] wr_data,
  input  logic [SW-1:0] rd_sel,
  output logic [TW-1:0] rd_data,
  output logic [SW-1:0] phase,
  output logic [TW-1:0] remain,
  output logic          phase_done,
  output logic          wr_err
);

  logic [NUM_PHASES-1:0][TW-1:0] dur;

  state_e        state_q, state_d;
  logic [SW-1:0] phase_q, phase_d;
  logic [TW-1:0] remain_q, remain_d;
  logic          done_q, done_d;
  logic [SW-1:0] nxt;
  logic [TW-1:0] nxt_dur;

  dur_bank #(
    .NUM_PHASES (NUM_PHASES),
    .TW         (TW),
    .SW         (SW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .wr_err  (wr_err),
    .dur_o   (dur)
  );

  // Bank values are pre-write this cycle, so
  // loads never see a same-edge write.
  always_comb begin
    if (int'(phase_q) == NUM_PHASES - 1)
      nxt = '0;
    else
      nxt = phase_q + SW'(1);
    nxt_dur = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (int'(nxt) == i)
        nxt_dur = dur[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    unique case (state_q)
      PAUSE: if (run)  state_d = COUNT;
      COUNT: if (!run) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
    if (restart) begin
      phase_d  = '0;
      remain_d = dur[0];
    end else if (state_d == COUNT && tick) begin
      if (remain_q > TW'(1)) begin
        remain_d = remain_q - TW'(1);
      end else begin
        phase_d  = nxt;
        remain_d = nxt_dur;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PAUSE;
      phase_q  <= '0;
      remain_q <= TW'(rst_dur(PH_RED));
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  assign phase      = phase_q;
  assign remain     = remain_q;
  assign phase_done = done_q;

endmodule
